axi_read_data_router: RTL
=========================

Name: axi_read_data_router

Overview:
- Read-data (R) channel stage directly downstream of the read-address controller in the 2-master / 2-slave AXI read interconnect.
- Observes each master's completed AR handshake and the decoded target slave, and records one outstanding burst per master.
- Routes R beats from the owning slave to the correct master until the RLAST handshake.
- Serialises two masters that target the same slave, in AR order, and checks burst length against ARLEN.

Parameters:
DATA_W, 32, R data width
LEN_W, 8, ARLEN width (beats = ARLEN+1)

Ports:
clkk  in  1  clock, rising edge
resett  in  1  reset; one clock; reset is asynchronous and active-high
M0_ARVALID  in  1  master 0 AR valid (as seen at interconnect)
M0_ARREADY  in  1  AR ready returned to master 0
M0_ARSLV  in  1  decoded slave for master 0 request (0=S0, 1=S1)
M0_ARLEN  in  LEN_W  master 0 burst length
M1_ARVALID, M1_ARREADY, M1_ARSLV, M1_ARLEN  in  1/1/1/LEN_W  same for master 1
S0_RVALID  in  1  slave 0 R valid
S0_RDATA  in  DATA_W  slave 0 R data
S0_RRESP  in  2  slave 0 R response
S0_RLAST  in  1  slave 0 R last
S0_RREADY  out  1  R ready to slave 0
S1_RVALID, S1_RDATA, S1_RRESP, S1_RLAST, S1_RREADY  as S0
M0_RVALID  out  1  R valid to master 0
M0_RDATA  out  DATA_W  R data to master 0
M0_RRESP  out  2  R response to master 0
M0_RLAST  out  1  R last to master 0
M0_RREADY  in  1  master 0 R ready
M1_RVALID, M1_RDATA, M1_RRESP, M1_RLAST, M1_RREADY  as M0
M0_busy, M1_busy  out  1  master has an outstanding burst (WAIT or ACTIVE)
len_err  out  2  one-cycle pulse per master [0]=M0 [1]=M1: RLAST/beat count mismatch
ar_drop  out  2  one-cycle pulse per master: AR accepted while already busy, ignored

Behaviour:
- Definitions:
  - ARhs_m = Mm_ARVALID & Mm_ARREADY.
  - Beat handshake on master m = Mm_RVALID & Mm_RREADY.
  - Final beat = beat handshake with RLAST=1.
- Per-master FSM with states IDLE, WAIT, ACTIVE. Each master also holds registers slv, len, cnt (LEN_W bits).
- IDLE, on ARhs:
  - Capture slv, len; set cnt=0.
  - If target slave is owned by the other master (WAIT or ACTIVE on same slv) and that master is not completing its final beat this cycle -> WAIT.
  - Otherwise -> ACTIVE.
- Simultaneous ARhs from both masters to the same free slave: M0 -> ACTIVE, M1 -> WAIT.
- WAIT: when the other master's final beat on the same slave completes -> ACTIVE next cycle.
- ACTIVE:
  - Each beat handshake increments cnt (wraps at 2^LEN_W).
  - Final beat -> IDLE.
  - If ARhs occurs in the same cycle as the final beat, capture the new request and go to ACTIVE/WAIT (back-to-back bursts are supported).
- ARhs while in WAIT, or while in ACTIVE without a final beat: request ignored; ar_drop[m] pulses for one cycle.
- Routing (combinational, zero latency), while master m is ACTIVE on slave s:
  - Mm_RVALID = Ss_RVALID.
  - Mm_RDATA, Mm_RRESP, Mm_RLAST = Ss fields.
  - Ss_RREADY = Mm_RREADY.
- When master m is not ACTIVE: Mm_RVALID=0, RDATA=0, RRESP=0, RLAST=0.
- A slave with no ACTIVE owner: RREADY=0, so unowned beats stall at the slave.
- A slave never has two ACTIVE owners.
- Length check:
  - Final beat with cnt != len -> len_err[m] pulses.
  - Beat handshake with cnt == len and RLAST=0 -> len_err[m] pulses; burst continues until RLAST.
- Reset:
  - Both FSMs -> IDLE; cnt/len/slv = 0.
  - All outputs 0: S*_RREADY, M*_RVALID, M*_RDATA, M*_RRESP, M*_RLAST, busy, len_err, ar_drop.
  - Reset asserted mid-burst abandons the burst immediately with no error pulse.
- Mm_busy = state != IDLE (registered state).

Test Plan:
- M0 ARhs slv=0 len=3; S0 sends 4 beats D0..D3 with RLAST on D3, M0_RREADY=1 -> M0 receives D0..D3 same cycle as S0; M0_busy falls the cycle after D3; S1_RREADY=0 throughout.
- M0 ARhs slv=1 len=0 and M1 ARhs slv=0 len=1 on consecutive cycles; both slaves return data concurrently -> each master receives only its own slave's data; no len_err.
- Both masters ARhs slv=0 in the same cycle (len=1 each) -> M0 ACTIVE, M1 WAIT; M1_RVALID=0 until M0's final beat; M1 receives S0's next 2 beats.
- M0 len=3, S0 asserts RLAST on beat 2 -> len_err=2'b01 for one cycle at that beat; M0 returns to IDLE.
- M0_RREADY held 0 for 5 cycles mid-burst -> S0_RREADY=0 for those cycles, cnt unchanged, data held; a second M0 ARhs during ACTIVE -> ar_drop=2'b01 and the request is ignored.
- Assert resett during beat 1 of a 4-beat burst -> all outputs 0 asynchronously; after release, a new burst routes correctly with cnt starting at 0.

Source files
------------

// File: rtl/axi_read_data_router.sv
// R-channel router for a 2-master / 2-slave AXI read interconnect: tracks one
// outstanding burst per master, serialises same-slave bursts in AR order and checks beat counts.
module axi_read_data_router #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clkk,
    input  logic              resett,
    input  logic              M0_ARVALID,
    input  logic              M0_ARREADY,
    input  logic              M0_ARSLV,
    input  logic [LEN_W-1:0]  M0_ARLEN,
    input  logic              M1_ARVALID,
    input  logic              M1_ARREADY,
    input  logic              M1_ARSLV,
    input  logic [LEN_W-1:0]  M1_ARLEN,
    input  logic              S0_RVALID,
    input  logic [DATA_W-1:0] S0_RDATA,
    input  logic [1:0]        S0_RRESP,
    input  logic              S0_RLAST,
    output logic              S0_RREADY,
    input  logic              S1_RVALID,
    input  logic [DATA_W-1:0] S1_RDATA,
    input  logic [1:0]        S1_RRESP,
    input  logic              S1_RLAST,
    output logic              S1_RREADY,
    output logic              M0_RVALID,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [1:0]        M0_RRESP,
    output logic              M0_RLAST,
    input  logic              M0_RREADY,
    output logic              M1_RVALID,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [1:0]        M1_RRESP,
    output logic              M1_RLAST,
    input  logic              M1_RREADY,
    output logic              M0_busy,
    output logic              M1_busy,
    output logic [1:0]        len_err,
    output logic [1:0]        ar_drop,
    output logic [3:0]        state_dbg
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid never waits on ready, and the routed R path is purely combinational.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state_q [2];
    state_t           state_d [2];
    logic             slv_q   [2];
    logic             slv_d   [2];
    logic [LEN_W-1:0] len_q   [2];
    logic [LEN_W-1:0] len_d   [2];
    logic [LEN_W-1:0] cnt_q   [2];
    logic [LEN_W-1:0] cnt_d   [2];

    logic              ar_hs    [2];
    logic              ar_slv   [2];
    logic [LEN_W-1:0]  ar_len   [2];
    logic              m_rready [2];
    logic              s_rvalid [2];
    logic [DATA_W-1:0] s_rdata  [2];
    logic [1:0]        s_rresp  [2];
    logic              s_rlast  [2];
    logic              m_rvalid [2];
    logic [DATA_W-1:0] m_rdata  [2];
    logic [1:0]        m_rresp  [2];
    logic              m_rlast  [2];
    logic              s_rready [2];
    logic              beat     [2];
    logic              fin      [2];
    logic              acc      [2];
    logic              conflict [2];

    assign ar_hs[0]    = M0_ARVALID & M0_ARREADY;
    assign ar_hs[1]    = M1_ARVALID & M1_ARREADY;
    assign ar_slv[0]   = M0_ARSLV;
    assign ar_slv[1]   = M1_ARSLV;
    assign ar_len[0]   = M0_ARLEN;
    assign ar_len[1]   = M1_ARLEN;
    assign m_rready[0] = M0_RREADY;
    assign m_rready[1] = M1_RREADY;
    assign s_rvalid[0] = S0_RVALID;
    assign s_rvalid[1] = S1_RVALID;
    assign s_rdata[0]  = S0_RDATA;
    assign s_rdata[1]  = S1_RDATA;
    assign s_rresp[0]  = S0_RRESP;
    assign s_rresp[1]  = S1_RRESP;
    assign s_rlast[0]  = S0_RLAST;
    assign s_rlast[1]  = S1_RLAST;

    assign M0_RVALID = m_rvalid[0];
    assign M0_RDATA  = m_rdata[0];
    assign M0_RRESP  = m_rresp[0];
    assign M0_RLAST  = m_rlast[0];
    assign M1_RVALID = m_rvalid[1];
    assign M1_RDATA  = m_rdata[1];
    assign M1_RRESP  = m_rresp[1];
    assign M1_RLAST  = m_rlast[1];
    assign S0_RREADY = s_rready[0];
    assign S1_RREADY = s_rready[1];

    always_comb begin : route
        for (int m = 0; m < 2; m++) begin
            m_rvalid[m] = 1'b0;
            m_rdata[m]  = '0;
            m_rresp[m]  = '0;
            m_rlast[m]  = 1'b0;
            if (state_q[m] == ACTIVE) begin
                m_rvalid[m] = s_rvalid[slv_q[m]];
                m_rdata[m]  = s_rdata[slv_q[m]];
                m_rresp[m]  = s_rresp[slv_q[m]];
                m_rlast[m]  = s_rlast[slv_q[m]];
            end
        end
        for (int s = 0; s < 2; s++) begin
            s_rready[s] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (state_q[m] == ACTIVE && slv_q[m] == s[0])
                    s_rready[s] = s_rready[s] | m_rready[m];
            end
        end
    end

    // M0 wins a tie: M1 also yields to a slave M0 is claiming in this same cycle.
    always_comb begin : handshakes
        for (int m = 0; m < 2; m++) begin
            beat[m] = m_rvalid[m] & m_rready[m];
            fin[m]  = beat[m] & m_rlast[m];
            acc[m]  = ar_hs[m] & ((state_q[m] == IDLE) | fin[m]);
        end
        conflict[0] = (state_q[1] != IDLE) && (slv_q[1] == ar_slv[0]) && !fin[1];
        conflict[1] = ((state_q[0] != IDLE) && (slv_q[0] == ar_slv[1]) && !fin[0])
                    || (acc[0] && (ar_slv[0] == ar_slv[1]));
    end

    always_comb begin : next_state
        for (int m = 0; m < 2; m++) begin
            state_d[m] = state_q[m];
            slv_d[m]   = slv_q[m];
            len_d[m]   = len_q[m];
            cnt_d[m]   = cnt_q[m];
            if (acc[m]) begin
                slv_d[m]   = ar_slv[m];
                len_d[m]   = ar_len[m];
                cnt_d[m]   = '0;
                state_d[m] = conflict[m] ? WAIT : ACTIVE;
            end else begin
                case (state_q[m])
                    WAIT: begin
                        if (fin[1-m] || !(state_q[1-m] != IDLE && slv_q[1-m] == slv_q[m]))
                            state_d[m] = ACTIVE;
                    end
                    ACTIVE: begin
                        if (beat[m])
                            cnt_d[m] = cnt_q[m] + 1'b1;
                        if (fin[m])
                            state_d[m] = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clkk or posedge resett) begin
        if (resett) begin
            for (int m = 0; m < 2; m++) begin
                state_q[m] <= IDLE;
                slv_q[m]   <= 1'b0;
                len_q[m]   <= '0;
                cnt_q[m]   <= '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                state_q[m] <= state_d[m];
                slv_q[m]   <= slv_d[m];
                len_q[m]   <= len_d[m];
                cnt_q[m]   <= cnt_d[m];
            end
        end
    end

    always_comb begin : outputs
        for (int m = 0; m < 2; m++) begin
            len_err[m] = beat[m] & (m_rlast[m] ? (cnt_q[m] != len_q[m])
                                               : (cnt_q[m] == len_q[m]));
            ar_drop[m] = ar_hs[m] & ~acc[m];
        end
    end

    assign M0_busy   = (state_q[0] != IDLE);
    assign M1_busy   = (state_q[1] != IDLE);
    assign state_dbg = {state_q[1], state_q[0]};

endmodule
